// File: rtl/dmem_seq_arbiter_pkg.sv
// Shared encodings for the two-port byte-sequenced data RAM arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BEATS  = 4;
  localparam int BEAT_W = 2;
  localparam int P_CPU  = 0;
  localparam int P_DBG  = 1;

  // Big-endian byte lane: beat 0 carries the most significant byte.
  function automatic logic [7:0] beat_byte(input logic [31:0] word,
                                           input logic [BEAT_W-1:0] beat);
    return word[8*(BEATS-1-int'(beat)) +: 8];
  endfunction

endpackage

// File: rtl/dmem_seq_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a sole requester wins, a tie goes to the
// port that was not granted last. Purely combinational, one-hot grant.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[P_CPU] && (!req_i[P_DBG] || last_grant_i == 1'(P_DBG))) begin
      gnt_o[P_CPU] = 1'b1;
    end else if (req_i[P_DBG]) begin
      gnt_o[P_DBG] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_seq_arbiter.sv
// Two-port word arbiter in front of a byte-wide RAM: each granted word access
// runs as four big-endian byte beats; all RAM and handshake outputs are registered.
module dmem_seq_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              wr0_i,
  input  logic              wr1_i,
  input  logic [31:0]       addr0_i,
  input  logic [31:0]       addr1_i,
  input  logic [31:0]       wdata0_i,
  input  logic [31:0]       wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic              err_o,
  output logic [31:0]       rdata_o,
  output logic              busy_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i
);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [1:0]          gnt;
  logic                grant, sel, sel_wr, sel_bad;
  logic [31:0]         sel_addr, sel_wdata;
  logic                last_grant_q, port_q, wr_q, bad_q;
  logic [ADDR_W-1:0]   base_q;
  logic [31:0]         wdata_q;
  logic [23:0]         rshift_q;
  logic [31:0]         rdata_q;
  logic                ack0_q, ack1_q, err_q, busy_q, ram_en_q, ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [7:0]          ram_wdata_q;

  rr_arb2 u_arb (
    .req_i        ({req1_i, req0_i}),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  assign sel       = gnt[P_DBG];
  assign sel_wr    = sel ? wr1_i    : wr0_i;
  assign sel_addr  = sel ? addr1_i  : addr0_i;
  assign sel_wdata = sel ? wdata1_i : wdata0_i;
  assign sel_bad   = (sel_addr[1:0] != 2'b00) || (sel_addr > 32'(DEPTH - 4));

  // Outputs lag the state by one cycle, so the ack cycle is spent in IDLE;
  // hold off grants then, since the acked requester may still show req.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|gnt) && !(ack0_q || ack1_q)) begin
          grant   = 1'b1;
          beat_d  = '0;
          state_d = sel_bad ? DONE : BEAT;
        end
      end
      BEAT: begin
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(BEATS - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      wr_q         <= 1'b0;
      bad_q        <= 1'b0;
      base_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (grant) begin
        last_grant_q <= sel;
        port_q       <= sel;
        wr_q         <= sel_wr;
        bad_q        <= sel_bad;
        base_q       <= sel_addr[ADDR_W-1:0];
        wdata_q      <= sel_wdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      rshift_q    <= '0;
      rdata_q     <= '0;
    end else begin
      ram_en_q    <= (state_q == BEAT);
      ram_we_q    <= (state_q == BEAT) && wr_q;
      ram_addr_q  <= (state_q == BEAT) ? base_q + ADDR_W'(beat_q) : '0;
      ram_wdata_q <= ((state_q == BEAT) && wr_q) ? beat_byte(wdata_q, beat_q) : 8'h00;
      ack0_q      <= (state_q == DONE) && (port_q == 1'(P_CPU));
      ack1_q      <= (state_q == DONE) && (port_q == 1'(P_DBG));
      err_q       <= (state_q == DONE) && bad_q;
      busy_q      <= (state_d != IDLE) || (state_q == DONE);
      if (ram_en_q && !ram_we_q) rshift_q <= {rshift_q[15:0], ram_rdata_i};
      // Last load byte is still on the bus in DONE; merge it straight in.
      if ((state_q == DONE) && !bad_q && !wr_q) rdata_q <= {rshift_q, ram_rdata_i};
    end
  end

  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign rdata_o     = rdata_q;
  assign ram_en_o    = ram_en_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_dmem_seq_arbiter.sv
// Directed bench for dmem_seq_arbiter: a byte RAM model plus a scoreboard of
// expected acks (port, err, rdata, latency, beat count) popped on each ack.
module tb_dmem_seq_arbiter;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  typedef struct {
    int          port;
    bit          err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [31:0]       addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic              ack0, ack1, err, busy, ram_en, ram_we;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata, ram_rdata;
  logic [7:0]        mem [DEPTH];

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_rd = '0;

  dmem_seq_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .req1_i(req1), .wr0_i(wr0), .wr1_i(wr1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0), .ack1_o(ack1), .err_o(err), .rdata_o(rdata), .busy_o(busy),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int port, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (port == 0) begin req0 = 1'b1; wr0 = wr; addr0 = addr; wdata0 = wdata; end
    else           begin req1 = 1'b1; wr1 = wr; addr1 = addr; wdata1 = wdata; end
  endtask

  task automatic expect_ack(input int port, input bit e, input logic [31:0] rd, input int lat);
    exp_t x;
    x.port = port; x.err = e; x.rdata = rd; x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic wait_ack(input bit keep);
    int   n = 0;
    int   en = 0;
    int   port;
    bit   got = 1'b0;
    exp_t e;
    while (!got && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ram_en) en++;
      got = ack0 | ack1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    if (got) begin
      port = ack1 ? 1 : 0;
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("ack_port", port, e.port);
        chk("ack_err", 32'(err), 32'(e.err));
        chk("rdata", rdata, e.rdata);
        chk("latency", n, e.lat);
        chk("beats", en, e.err ? 0 : 4);
      end
      if (!keep) begin
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    chk("ack_one_cycle", 32'(ack0 | ack1), 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack0"}, 32'(ack0), 0);
    chk({tag, "_ack1"}, 32'(ack1), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_ram_en"}, 32'(ram_en), 0);
    chk({tag, "_ram_we"}, 32'(ram_we), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    chk({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
  endtask

  initial begin
    bit hit;
    int acks;
    #1 chk_quiet("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Store then load on port 0
    drive(0, 1'b1, 32'd8, 32'h11223344);
    expect_ack(0, 1'b0, last_rd, 6);
    wait_ack(1'b0); settle();
    chk("mem_8_11", {mem[8], mem[9], mem[10], mem[11]}, 32'h11223344);
    drive(0, 1'b0, 32'd8, 32'h0);
    last_rd = 32'h11223344;
    expect_ack(0, 1'b0, last_rd, 6);
    wait_ack(1'b0); settle();

    // Seed words 0 and 4 for the tie test
    drive(0, 1'b1, 32'd0, 32'hA0A1A2A3);
    expect_ack(0, 1'b0, last_rd, 6);
    wait_ack(1'b0); settle();
    drive(1, 1'b1, 32'd4, 32'hB0B1B2B3);
    expect_ack(1, 1'b0, last_rd, 6);
    wait_ack(1'b0); settle();

    // Fresh reset, both ports loading and held: grants go 0,1,0,1
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    drive(0, 1'b0, 32'd0, 32'h0);
    drive(1, 1'b0, 32'd4, 32'h0);
    expect_ack(0, 1'b0, 32'hA0A1A2A3, 6);
    expect_ack(1, 1'b0, 32'hB0B1B2B3, 7);
    expect_ack(0, 1'b0, 32'hA0A1A2A3, 7);
    expect_ack(1, 1'b0, 32'hB0B1B2B3, 7);
    wait_ack(1'b1); wait_ack(1'b1); wait_ack(1'b1); wait_ack(1'b0);
    req0 = 1'b0;
    last_rd = 32'hB0B1B2B3;
    settle();

    // Misaligned address rejects without touching the RAM
    drive(0, 1'b0, 32'd6, 32'h0);
    expect_ack(0, 1'b1, last_rd, 2);
    wait_ack(1'b0); settle();

    // Last word is legal, one past it is not
    drive(1, 1'b1, 32'd28, 32'hC0FFEE01);
    expect_ack(1, 1'b0, last_rd, 6);
    wait_ack(1'b0); settle();
    drive(1, 1'b0, 32'd28, 32'h0);
    last_rd = 32'hC0FFEE01;
    expect_ack(1, 1'b0, last_rd, 6);
    wait_ack(1'b0); settle();
    drive(1, 1'b0, 32'd32, 32'h0);
    expect_ack(1, 1'b1, last_rd, 2);
    wait_ack(1'b0); settle();

    // Reset during beat 2 of a store
    drive(0, 1'b1, 32'd12, 32'h01020304);
    expect_ack(0, 1'b0, last_rd, 6);
    wait_ack(1'b0); settle();
    drive(0, 1'b1, 32'd12, 32'hAABBCCDD);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (ram_en && ram_we && ram_addr == 5'd14) hit = 1'b1;
    end
    chk("beat2_seen", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1 chk_quiet("midreset");
    acks = 0;
    req0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (ack0 || ack1) acks++;
    end
    chk("midreset_no_ack", acks, 0);
    chk("mem_12_15", {mem[12], mem[13], mem[14], mem[15]}, 32'hAABB0304);
    last_rd = '0;

    // req0 held through ack: identical access repeats 7 cycles later
    drive(0, 1'b0, 32'd8, 32'h0);
    expect_ack(0, 1'b0, 32'h11223344, 6);
    expect_ack(0, 1'b0, 32'h11223344, 7);
    wait_ack(1'b1); wait_ack(1'b0); settle();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
